// File: rtl/liang_pkg.sv
// Shared AXI-lite types for the SRAM responder and its storage.
package liang_pkg;

   localparam int unsigned AXI_ADDR_W = 32;
   localparam int unsigned AXI_DATA_W = 32;
   localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;

   typedef logic [AXI_ADDR_W-1:0] axi_addr_t;
   typedef logic [AXI_DATA_W-1:0] axi_data_t;
   typedef logic [AXI_STRB_W-1:0] axi_strb_t;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } axi_resp_e;

   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_e;
   typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_e;

   // Captured W-channel beat.
   typedef struct packed {
      axi_data_t data;
      axi_strb_t strb;
   } axi_w_t;

endpackage

// File: rtl/sram_1r1w_be.sv
// Word-addressed SRAM: one synchronous read port, one byte-enable write port.
// A same-address read and write in one cycle returns the pre-write word.
module sram_1r1w_be
   import liang_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 4096,
   parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             rd_en_i,
   input  logic             rd_hit_i,
   input  logic [IDX_W-1:0] rd_idx_i,
   output axi_data_t        rd_data_o,
   input  logic             wr_en_i,
   input  logic [IDX_W-1:0] wr_idx_i,
   input  axi_data_t        wr_data_i,
   input  axi_strb_t        wr_strb_i
);

   axi_data_t mem [DEPTH_WORDS];
   axi_data_t rd_data_q;
   axi_data_t rd_data_d;

   // Misses load zero so the response data is already clean.
   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en_i) begin
         rd_data_d = rd_hit_i ? mem[rd_idx_i] : '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   // Storage is intentionally not reset.
   always_ff @(posedge clk_i) begin
      for (int k = 0; k < int'(AXI_STRB_W); k++) begin
         if (wr_en_i && wr_strb_i[k]) begin
            mem[wr_idx_i][8*k +: 8] <= wr_data_i[8*k +: 8];
         end
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/axi_lite_sram_slave.sv
// AXI-lite responder over a word SRAM with independent read and write channels,
// programmable response latency, byte strobes and DECERR outside the window.
module axi_lite_sram_slave
   import liang_pkg::*;
#(
   parameter axi_addr_t   BASE_ADDR   = 32'h8000_0000,
   parameter int unsigned DEPTH_WORDS = 4096,
   parameter int unsigned RD_LAT      = 1,
   parameter int unsigned WR_LAT      = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] araddr_i,
   input  logic        arvalid_i,
   output logic        arready_o,
   output logic [31:0] rdata_o,
   output logic [1:0]  rresp_o,
   output logic        rvalid_o,
   input  logic        rready_i,
   input  logic [31:0] awaddr_i,
   input  logic        awvalid_i,
   output logic        awready_o,
   input  logic [31:0] wdata_i,
   input  logic [3:0]  wstrb_i,
   input  logic        wvalid_i,
   output logic        wready_o,
   output logic [1:0]  bresp_o,
   output logic        bvalid_o,
   input  logic        bready_i
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
   localparam int unsigned CNT_W = 16;
   localparam axi_addr_t   SPAN  = axi_addr_t'(4 * DEPTH_WORDS);

   function automatic logic addr_hit(input axi_addr_t a);
      return (a >= BASE_ADDR) && ((a - BASE_ADDR) < SPAN);
   endfunction

   function automatic logic [IDX_W-1:0] addr_idx(input axi_addr_t a);
      return IDX_W'((a - BASE_ADDR) >> 2);
   endfunction

   // ---------------- read channel state ----------------
   rd_state_e          rd_state_q, rd_state_d;
   logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
   axi_addr_t          rd_addr_q, rd_addr_d;
   logic               arready_q, arready_d;
   logic               rvalid_q, rvalid_d;
   axi_resp_e          rresp_q, rresp_d;
   logic               rd_en_c;
   axi_addr_t          rd_sel_addr_c;

   always_comb begin
      rd_state_d    = rd_state_q;
      rd_cnt_d      = rd_cnt_q;
      rd_addr_d     = rd_addr_q;
      rresp_d       = rresp_q;
      rd_en_c       = 1'b0;
      rd_sel_addr_c = rd_addr_q;
      case (rd_state_q)
         R_IDLE: begin
            if (arvalid_i && arready_q) begin
               rd_addr_d = araddr_i;
               if (RD_LAT <= 1) begin
                  rd_en_c       = 1'b1;
                  rd_sel_addr_c = araddr_i;
                  rresp_d       = addr_hit(araddr_i) ? RESP_OKAY : RESP_DECERR;
                  rd_state_d    = R_RESP;
               end else begin
                  rd_cnt_d   = CNT_W'(RD_LAT - 2);
                  rd_state_d = R_WAIT;
               end
            end
         end
         R_WAIT: begin
            if (rd_cnt_q == '0) begin
               rd_en_c    = 1'b1;
               rresp_d    = addr_hit(rd_addr_q) ? RESP_OKAY : RESP_DECERR;
               rd_state_d = R_RESP;
            end else begin
               rd_cnt_d = rd_cnt_q - CNT_W'(1);
            end
         end
         R_RESP: begin
            if (rready_i) begin
               rd_state_d = R_IDLE;
            end
         end
         default: rd_state_d = R_IDLE;
      endcase
      arready_d = (rd_state_d == R_IDLE);
      rvalid_d  = (rd_state_d == R_RESP);
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         rd_state_q <= R_IDLE;
         rd_cnt_q   <= '0;
         rd_addr_q  <= '0;
         arready_q  <= 1'b1;
         rvalid_q   <= 1'b0;
         rresp_q    <= RESP_OKAY;
      end else begin
         rd_state_q <= rd_state_d;
         rd_cnt_q   <= rd_cnt_d;
         rd_addr_q  <= rd_addr_d;
         arready_q  <= arready_d;
         rvalid_q   <= rvalid_d;
         rresp_q    <= rresp_d;
      end
   end

   // ---------------- write channel state ----------------
   wr_state_e          wr_state_q, wr_state_d;
   logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
   axi_addr_t          wr_addr_q, wr_addr_d;
   axi_w_t             wr_pay_q, wr_pay_d;
   logic               aw_held_q, aw_held_d;
   logic               w_held_q, w_held_d;
   logic               awready_q, awready_d;
   logic               wready_q, wready_d;
   logic               bvalid_q, bvalid_d;
   axi_resp_e          bresp_q, bresp_d;
   logic               wr_en_c;

   always_comb begin
      wr_state_d = wr_state_q;
      wr_cnt_d   = wr_cnt_q;
      wr_addr_d  = wr_addr_q;
      wr_pay_d   = wr_pay_q;
      aw_held_d  = aw_held_q;
      w_held_d   = w_held_q;
      bresp_d    = bresp_q;
      wr_en_c    = 1'b0;
      case (wr_state_q)
         W_IDLE: begin
            if (awvalid_i && awready_q) begin
               wr_addr_d = awaddr_i;
               aw_held_d = 1'b1;
            end
            if (wvalid_i && wready_q) begin
               wr_pay_d = '{data: wdata_i, strb: wstrb_i};
               w_held_d = 1'b1;
            end
            // AW and W may arrive in either order; start once both are held.
            if (aw_held_d && w_held_d) begin
               aw_held_d  = 1'b0;
               w_held_d   = 1'b0;
               wr_cnt_d   = CNT_W'(WR_LAT - 1);
               wr_state_d = W_WAIT;
            end
         end
         W_WAIT: begin
            if (wr_cnt_q == '0) begin
               wr_en_c    = addr_hit(wr_addr_q);
               bresp_d    = addr_hit(wr_addr_q) ? RESP_OKAY : RESP_DECERR;
               wr_state_d = W_RESP;
            end else begin
               wr_cnt_d = wr_cnt_q - CNT_W'(1);
            end
         end
         W_RESP: begin
            if (bready_i) begin
               wr_state_d = W_IDLE;
            end
         end
         default: wr_state_d = W_IDLE;
      endcase
      awready_d = (wr_state_d == W_IDLE) && !aw_held_d;
      wready_d  = (wr_state_d == W_IDLE) && !w_held_d;
      bvalid_d  = (wr_state_d == W_RESP);
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wr_state_q <= W_IDLE;
         wr_cnt_q   <= '0;
         wr_addr_q  <= '0;
         wr_pay_q   <= '0;
         aw_held_q  <= 1'b0;
         w_held_q   <= 1'b0;
         awready_q  <= 1'b1;
         wready_q   <= 1'b1;
         bvalid_q   <= 1'b0;
         bresp_q    <= RESP_OKAY;
      end else begin
         wr_state_q <= wr_state_d;
         wr_cnt_q   <= wr_cnt_d;
         wr_addr_q  <= wr_addr_d;
         wr_pay_q   <= wr_pay_d;
         aw_held_q  <= aw_held_d;
         w_held_q   <= w_held_d;
         awready_q  <= awready_d;
         wready_q   <= wready_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
      end
   end

   sram_1r1w_be #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_sram (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .rd_en_i   (rd_en_c),
      .rd_hit_i  (addr_hit(rd_sel_addr_c)),
      .rd_idx_i  (addr_idx(rd_sel_addr_c)),
      .rd_data_o (rdata_o),
      .wr_en_i   (wr_en_c),
      .wr_idx_i  (addr_idx(wr_addr_q)),
      .wr_data_i (wr_pay_q.data),
      .wr_strb_i (wr_pay_q.strb)
   );

   assign arready_o = arready_q;
   assign rvalid_o  = rvalid_q;
   assign rresp_o   = rresp_q;
   assign awready_o = awready_q;
   assign wready_o  = wready_q;
   assign bvalid_o  = bvalid_q;
   assign bresp_o   = bresp_q;

endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// Directed + randomized bench for axi_lite_sram_slave: two instances (slow/fast latency)
// share one stimulus bus, selected by 'sel', checked against a word-array reference model.
module tb_axi_lite_sram_slave;

   localparam logic [31:0] BASE  = 32'h8000_0000;
   localparam int          DEPTH = 4096;

   logic clk = 1'b0;
   logic rst_i = 1'b0;
   always #5 clk = ~clk;

   logic        sel = 1'b0;   // 0: slow instance (RD_LAT 3, WR_LAT 2), 1: fast (1/1)
   logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        arvalid = 1'b0, rready = 1'b0, awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;

   logic        a_arready, a_rvalid, a_awready, a_wready, a_bvalid;
   logic [31:0] a_rdata;
   logic [1:0]  a_rresp, a_bresp;
   logic        b_arready, b_rvalid, b_awready, b_wready, b_bvalid;
   logic [31:0] b_rdata;
   logic [1:0]  b_rresp, b_bresp;

   axi_lite_sram_slave #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .RD_LAT(3), .WR_LAT(2)) dut_a (
      .clk_i(clk), .rst_i(rst_i),
      .araddr_i(araddr), .arvalid_i(arvalid && !sel), .arready_o(a_arready),
      .rdata_o(a_rdata), .rresp_o(a_rresp), .rvalid_o(a_rvalid), .rready_i(rready && !sel),
      .awaddr_i(awaddr), .awvalid_i(awvalid && !sel), .awready_o(a_awready),
      .wdata_i(wdata), .wstrb_i(wstrb), .wvalid_i(wvalid && !sel), .wready_o(a_wready),
      .bresp_o(a_bresp), .bvalid_o(a_bvalid), .bready_i(bready && !sel));

   axi_lite_sram_slave #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .RD_LAT(1), .WR_LAT(1)) dut_b (
      .clk_i(clk), .rst_i(rst_i),
      .araddr_i(araddr), .arvalid_i(arvalid && sel), .arready_o(b_arready),
      .rdata_o(b_rdata), .rresp_o(b_rresp), .rvalid_o(b_rvalid), .rready_i(rready && sel),
      .awaddr_i(awaddr), .awvalid_i(awvalid && sel), .awready_o(b_awready),
      .wdata_i(wdata), .wstrb_i(wstrb), .wvalid_i(wvalid && sel), .wready_o(b_wready),
      .bresp_o(b_bresp), .bvalid_o(b_bvalid), .bready_i(bready && sel));

   wire        arready = sel ? b_arready : a_arready;
   wire        rvalid  = sel ? b_rvalid  : a_rvalid;
   wire [31:0] rdata   = sel ? b_rdata   : a_rdata;
   wire [1:0]  rresp   = sel ? b_rresp   : a_rresp;
   wire        awready = sel ? b_awready : a_awready;
   wire        wready  = sel ? b_wready  : a_wready;
   wire        bvalid  = sel ? b_bvalid  : a_bvalid;
   wire [1:0]  bresp   = sel ? b_bresp   : a_bresp;

   int total = 0;
   int bad   = 0;

   // Reference memory keyed by instance and word index.
   bit [31:0] model [int];

   function automatic bit in_win(input logic [31:0] a);
      return (a >= BASE) && (a < BASE + 32'(4 * DEPTH));
   endfunction

   function automatic int mkey(input logic s, input logic [31:0] a);
      return (s ? DEPTH : 0) + int'((a - BASE) >> 2);
   endfunction

   function automatic int rd_lat();
      return sel ? 1 : 3;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
      bit [31:0] w;
      if (!in_win(addr)) return;
      w = model.exists(mkey(sel, addr)) ? model[mkey(sel, addr)] : 32'h0;
      for (int k = 0; k < 4; k++)
         if (strb[k]) w[8*k +: 8] = data[8*k +: 8];
      model[mkey(sel, addr)] = w;
   endtask

   function automatic logic [31:0] model_read(input logic [31:0] addr);
      if (!in_win(addr)) return 32'h0;
      return model.exists(mkey(sel, addr)) ? model[mkey(sel, addr)] : 32'h0;
   endfunction

   // lead = cycles W precedes AW (0: same cycle); bhold = cycles bready held low.
   task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int lead, input int bhold, input string tag);
      int n;
      logic [1:0] exp_resp;
      exp_resp = in_win(addr) ? 2'b00 : 2'b11;
      chk({tag, ".awready_idle"}, 32'(awready), 32'd1);
      chk({tag, ".wready_idle"}, 32'(wready), 32'd1);
      awaddr = addr; wdata = data; wstrb = strb;
      if (lead == 0) begin
         awvalid = 1'b1; wvalid = 1'b1; step(); awvalid = 1'b0; wvalid = 1'b0;
      end else begin
         wvalid = 1'b1; step(); wvalid = 1'b0;
         chk({tag, ".wready_after_w"}, 32'(wready), 32'd0);
         chk({tag, ".awready_after_w"}, 32'(awready), 32'd1);
         repeat (lead - 1) step();
         awvalid = 1'b1; step(); awvalid = 1'b0;
      end
      chk({tag, ".awready_busy"}, 32'(awready), 32'd0);
      chk({tag, ".wready_busy"}, 32'(wready), 32'd0);
      model_write(addr, data, strb);
      n = 0;
      while (!bvalid && n < 20) begin step(); n++; end
      chk({tag, ".bvalid"}, 32'(bvalid), 32'd1);
      chk({tag, ".bresp"}, 32'(bresp), 32'(exp_resp));
      awvalid = 1'b1; wvalid = 1'b1;
      for (int i = 0; i < bhold; i++) begin
         step();
         chk({tag, ".bvalid_hold"}, 32'(bvalid), 32'd1);
         chk({tag, ".bresp_hold"}, 32'(bresp), 32'(exp_resp));
         chk({tag, ".awready_hold"}, 32'(awready), 32'd0);
         chk({tag, ".wready_hold"}, 32'(wready), 32'd0);
      end
      awvalid = 1'b0; wvalid = 1'b0;
      bready = 1'b1; step(); bready = 1'b0;
      chk({tag, ".bvalid_done"}, 32'(bvalid), 32'd0);
      chk({tag, ".awready_done"}, 32'(awready), 32'd1);
   endtask

   // rhold = cycles rready held low after rvalid rises.
   task automatic do_read(input logic [31:0] addr, input int rhold, input string tag);
      int n;
      logic [31:0] exp_d;
      logic [1:0]  exp_resp;
      exp_d = model_read(addr);
      exp_resp = in_win(addr) ? 2'b00 : 2'b11;
      chk({tag, ".arready_idle"}, 32'(arready), 32'd1);
      araddr = addr; arvalid = 1'b1; step(); arvalid = 1'b0;
      n = 1;
      while (!rvalid && n < 20) begin
         chk({tag, ".arready_wait"}, 32'(arready), 32'd0);
         step(); n++;
      end
      chk({tag, ".latency"}, 32'(n), 32'(rd_lat()));
      chk({tag, ".rvalid"}, 32'(rvalid), 32'd1);
      chk({tag, ".rdata"}, rdata, exp_d);
      chk({tag, ".rresp"}, 32'(rresp), 32'(exp_resp));
      for (int i = 0; i < rhold; i++) begin
         step();
         chk({tag, ".rvalid_hold"}, 32'(rvalid), 32'd1);
         chk({tag, ".rdata_hold"}, rdata, exp_d);
         chk({tag, ".arready_hold"}, 32'(arready), 32'd0);
      end
      rready = 1'b1; step(); rready = 1'b0;
      chk({tag, ".rvalid_done"}, 32'(rvalid), 32'd0);
      chk({tag, ".arready_done"}, 32'(arready), 32'd1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] addr, data, old_v, new_v;
      int n;

      // Reset state of both instances.
      #12;
      for (int s = 0; s < 2; s++) begin
         sel = s[0]; #1;
         chk("rst.rdata", rdata, 32'h0);
         chk("rst.rresp", 32'(rresp), 32'd0);
         chk("rst.bresp", 32'(bresp), 32'd0);
         chk("rst.rvalid", 32'(rvalid), 32'd0);
         chk("rst.bvalid", 32'(bvalid), 32'd0);
         chk("rst.arready", 32'(arready), 32'd1);
         chk("rst.awready", 32'(awready), 32'd1);
         chk("rst.wready", 32'(wready), 32'd1);
      end
      @(negedge clk); rst_i = 1'b1;
      step();

      // Full-word write and read back, then partial strobes, on both instances.
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, "t1.wr");
         do_read(32'h8000_0010, 0, "t1.rd");
         do_write(32'h8000_0010, 32'h1122_3344, 4'b0101, 0, 0, "t2.wr");
         do_read(32'h8000_0010, 0, "t2.rd");
         chk("t2.merged", rdata, 32'hDE22_BE44);
      end

      // W two cycles ahead of AW, B held off for 5 cycles.
      sel = 1'b0;
      do_write(32'h8000_0020, $urandom, 4'hF, 2, 5, "t3.wr");
      do_read(32'h8000_0020, 0, "t3.rd");

      // Window edges: last word hit, one-below and one-past misses.
      do_write(32'h8000_3FFC, 32'hA5A5_0001, 4'hF, 0, 0, "t4.last");
      do_read(32'h7FFF_FFFC, 0, "t4.rd_miss");
      do_write(32'h8000_4000, 32'hFFFF_FFFF, 4'hF, 0, 0, "t4.wr_miss");
      do_read(32'h8000_3FFC, 0, "t4.last_rd");
      do_read(32'h8000_0010, 0, "t4.word_rd");

      // Slow instance: held R response, then read and write to one word in the same cycle.
      do_read(32'h8000_0010, 4, "t5.hold");
      old_v = model_read(32'h8000_0010);
      new_v = $urandom;
      araddr = 32'h8000_0010; awaddr = 32'h8000_0010; wdata = new_v; wstrb = 4'hF;
      arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
      step();
      arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
      model_write(32'h8000_0010, new_v, 4'hF);
      n = 0;
      while (!rvalid && n < 20) begin step(); n++; end
      chk("t5.coll_rvalid", 32'(rvalid), 32'd1);
      chk("t5.coll_old", rdata, old_v);
      rready = 1'b1; step(); rready = 1'b0;
      n = 0;
      while (!bvalid && n < 20) begin step(); n++; end
      chk("t5.coll_bvalid", 32'(bvalid), 32'd1);
      chk("t5.coll_bresp", 32'(bresp), 32'd0);
      bready = 1'b1; step(); bready = 1'b0;
      do_read(32'h8000_0010, 0, "t5.coll_new");

      // Seed words 0..15 on both instances, then randomized traffic.
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         for (int w = 0; w < 16; w++)
            do_write(BASE + 32'(4 * w), $urandom, 4'hF, 0, 0, "seed");
      end
      for (int i = 0; i < 24; i++) begin
         sel = i[0];
         addr = BASE + 32'(4 * $urandom_range(0, 15));
         if ($urandom_range(0, 5) == 0) addr = BASE + 32'h4000 + 32'(4 * $urandom_range(0, 7));
         data = $urandom;
         do_write(addr, data, 4'($urandom_range(0, 15)), int'($urandom_range(0, 2)),
                  int'($urandom_range(0, 2)), "rnd.wr");
         addr = BASE + 32'(4 * $urandom_range(0, 15));
         if ($urandom_range(0, 5) == 0) addr = BASE - 32'(4 * $urandom_range(1, 8));
         do_read(addr, int'($urandom_range(0, 2)), "rnd.rd");
      end

      // Async reset while both channels of the slow instance are mid-transaction.
      sel = 1'b0;
      old_v = model_read(32'h8000_0014);
      araddr = 32'h8000_0014; awaddr = 32'h8000_0014; wdata = ~old_v; wstrb = 4'hF;
      arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
      step();
      arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
      chk("t6.arready_busy", 32'(arready), 32'd0);
      chk("t6.awready_busy", 32'(awready), 32'd0);
      rst_i = 1'b0;
      #1;
      chk("t6.rvalid", 32'(rvalid), 32'd0);
      chk("t6.bvalid", 32'(bvalid), 32'd0);
      chk("t6.arready", 32'(arready), 32'd1);
      chk("t6.awready", 32'(awready), 32'd1);
      chk("t6.wready", 32'(wready), 32'd1);
      repeat (3) @(posedge clk);
      @(negedge clk); rst_i = 1'b1;
      step();
      do_read(32'h8000_0014, 0, "t6.unmodified");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
